// File: rtl/lu_pkg.sv
// Shared types, defaults and FSM state codes for the LU row scheduler slice.
package lu_pkg;

  localparam int unsigned LU_SIZE     = 4;
  localparam int unsigned LU_WIDTH    = 64;
  localparam int unsigned LU_START_TO = 64;

  // One complex element; imag occupies the upper half.
  typedef struct packed {
    logic [LU_WIDTH-1:0] im;
    logic [LU_WIDTH-1:0] re;
  } cplx_t;

  typedef cplx_t [LU_SIZE-1:0] row_t;

  typedef logic [2:0] sched_state_e;

  localparam sched_state_e ST_IDLE      = 3'd0;
  localparam sched_state_e ST_START     = 3'd1;
  localparam sched_state_e ST_WAIT_BUSY = 3'd2;
  localparam sched_state_e ST_RUN       = 3'd3;
  localparam sched_state_e ST_DONE      = 3'd4;

  // Replicate one element across a whole row.
  function automatic row_t row_fill(input cplx_t e);
    row_t r;
    for (int j = 0; j < int'(LU_SIZE); j++) r[j] = e;
    return r;
  endfunction

endpackage

// File: rtl/lu_row_mem.sv
// Row register file: one write port, one registered read port with write-first bypass.
module lu_row_mem #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned ROW_W = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(SIZE)-1:0] wr_addr,
  input  logic [ROW_W-1:0]        wr_data,
  input  logic                    rd_en,
  input  logic [$clog2(SIZE)-1:0] rd_addr,
  output logic [ROW_W-1:0]        rd_data
);

  logic [ROW_W-1:0] store [SIZE];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) store[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : store[rd_addr];
    end
  end

endmodule

// File: rtl/lu_row_sched.sv
// Owns the matrix row store and sequences the lu engine: load, start, serve, finish.
module lu_row_sched
  import lu_pkg::*;
#(
  parameter int unsigned SIZE     = LU_SIZE,
  parameter int unsigned WIDTH    = LU_WIDTH,
  parameter int unsigned START_TO = LU_START_TO
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        host_wr_valid_i,
  output logic                        host_wr_ready_o,
  input  logic [$clog2(SIZE)-1:0]     host_wr_addr_i,
  input  logic [SIZE*2*WIDTH-1:0]     host_wr_row_i,
  input  logic                        host_rd_valid_i,
  output logic                        host_rd_ready_o,
  input  logic [$clog2(SIZE)-1:0]     host_rd_addr_i,
  output logic [SIZE*2*WIDTH-1:0]     host_rd_row_o,
  output logic                        host_rd_row_valid_o,
  input  logic                        go_i,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic                        lu_start_o,
  input  logic                        lu_busy_i,
  input  logic [$clog2(SIZE)-1:0]     lu_rd_addr_i,
  input  logic                        lu_rd_addr_valid_i,
  output logic [SIZE*2*WIDTH-1:0]     lu_row_o,
  output logic [$clog2(SIZE)-1:0]     lu_row_addr_o,
  output logic                        lu_row_valid_o,
  input  logic [SIZE*2*WIDTH-1:0]     lu_wr_row_i,
  input  logic [$clog2(SIZE)-1:0]     lu_wr_addr_i,
  input  logic                        lu_wr_valid_i,
  output logic                        lu_wr_ready_o
);

  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned ROW_W = SIZE * 2 * WIDTH;
  localparam int unsigned CW    = $clog2(START_TO + 1);

  sched_state_e    state, state_nxt;
  logic [SIZE-1:0] loaded, loaded_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            err_nxt;

  logic             host_wr_acc, host_rd_acc, lu_wr_acc, lu_rd_acc, lu_phase;
  logic             mem_wr_en, mem_rd_en;
  logic [AW-1:0]    mem_wr_addr, mem_rd_addr;
  logic [ROW_W-1:0] mem_wr_data, mem_rd_data;

  // Port ownership follows the phase: host in IDLE, engine while the run is live.
  assign lu_phase    = (state == ST_WAIT_BUSY) || (state == ST_RUN);
  assign host_wr_acc = host_wr_valid_i && host_wr_ready_o;
  assign host_rd_acc = host_rd_valid_i && host_rd_ready_o;
  assign lu_wr_acc   = lu_wr_valid_i && lu_wr_ready_o;
  assign lu_rd_acc   = lu_rd_addr_valid_i && lu_phase;

  assign mem_wr_en   = host_wr_acc || lu_wr_acc;
  assign mem_wr_addr = host_wr_acc ? host_wr_addr_i : lu_wr_addr_i;
  assign mem_wr_data = host_wr_acc ? host_wr_row_i : lu_wr_row_i;
  assign mem_rd_en   = host_rd_acc || lu_rd_acc;
  assign mem_rd_addr = host_rd_acc ? host_rd_addr_i : lu_rd_addr_i;

  lu_row_mem #(
    .SIZE  (SIZE),
    .ROW_W (ROW_W)
  ) u_mem (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

  assign host_rd_row_o = mem_rd_data;
  assign lu_row_o      = mem_rd_data;

  // Next-state, load mask and start-timeout counter.
  always_comb begin
    state_nxt  = state;
    loaded_nxt = loaded;
    cnt_nxt    = cnt;
    err_nxt    = 1'b0;
    if (host_wr_acc) loaded_nxt = loaded | (SIZE'(1) << host_wr_addr_i);
    case (state)
      ST_IDLE: begin
        if (go_i) begin
          if (&loaded) state_nxt = ST_START;
          else         err_nxt   = 1'b1;
        end
      end
      ST_START: begin
        cnt_nxt   = '0;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (lu_busy_i) begin
          state_nxt = ST_RUN;
        end else if (cnt == CW'(START_TO - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (!lu_busy_i) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        loaded_nxt = '0;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State plus status outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      loaded          <= '0;
      cnt             <= '0;
      lu_start_o      <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      busy_o          <= 1'b0;
      host_wr_ready_o <= 1'b1;
      host_rd_ready_o <= 1'b1;
      lu_wr_ready_o   <= 1'b0;
    end else begin
      state           <= state_nxt;
      loaded          <= loaded_nxt;
      cnt             <= cnt_nxt;
      lu_start_o      <= (state_nxt == ST_START);
      done_o          <= (state_nxt == ST_DONE);
      err_o           <= err_nxt;
      busy_o          <= (state_nxt != ST_IDLE);
      host_wr_ready_o <= (state_nxt == ST_IDLE);
      host_rd_ready_o <= (state_nxt == ST_IDLE);
      lu_wr_ready_o   <= (state_nxt == ST_RUN);
    end
  end

  // Read-response qualifiers track the accepted request by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      host_rd_row_valid_o <= 1'b0;
      lu_row_valid_o      <= 1'b0;
      lu_row_addr_o       <= '0;
    end else begin
      host_rd_row_valid_o <= host_rd_acc;
      lu_row_valid_o      <= lu_rd_acc;
      if (lu_rd_acc) lu_row_addr_o <= lu_rd_addr_i;
    end
  end

endmodule

// File: tb/tb_lu_row_sched.sv
// Randomized scoreboard bench for lu_row_sched against a row-array reference model.
module tb_lu_row_sched;
  import lu_pkg::*;

  localparam int unsigned SIZE     = LU_SIZE;
  localparam int unsigned WIDTH    = LU_WIDTH;
  localparam int unsigned START_TO = 16;
  localparam int unsigned AW       = $clog2(SIZE);
  localparam int unsigned ROW_W    = SIZE * 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             host_wr_valid_i = 1'b0, host_rd_valid_i = 1'b0;
  logic [AW-1:0]    host_wr_addr_i = '0, host_rd_addr_i = '0;
  logic [ROW_W-1:0] host_wr_row_i = '0;
  logic             go_i = 1'b0, lu_busy_i = 1'b0;
  logic [AW-1:0]    lu_rd_addr_i = '0, lu_wr_addr_i = '0;
  logic             lu_rd_addr_valid_i = 1'b0, lu_wr_valid_i = 1'b0;
  logic [ROW_W-1:0] lu_wr_row_i = '0;

  logic             host_wr_ready_o, host_rd_ready_o, host_rd_row_valid_o;
  logic [ROW_W-1:0] host_rd_row_o, lu_row_o;
  logic             done_o, err_o, busy_o, lu_start_o, lu_row_valid_o, lu_wr_ready_o;
  logic [AW-1:0]    lu_row_addr_o;

  lu_row_sched #(.SIZE(SIZE), .WIDTH(WIDTH), .START_TO(START_TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_wr_valid_i(host_wr_valid_i), .host_wr_ready_o(host_wr_ready_o),
    .host_wr_addr_i(host_wr_addr_i), .host_wr_row_i(host_wr_row_i),
    .host_rd_valid_i(host_rd_valid_i), .host_rd_ready_o(host_rd_ready_o),
    .host_rd_addr_i(host_rd_addr_i), .host_rd_row_o(host_rd_row_o),
    .host_rd_row_valid_o(host_rd_row_valid_o),
    .go_i(go_i), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .lu_start_o(lu_start_o), .lu_busy_i(lu_busy_i),
    .lu_rd_addr_i(lu_rd_addr_i), .lu_rd_addr_valid_i(lu_rd_addr_valid_i),
    .lu_row_o(lu_row_o), .lu_row_addr_o(lu_row_addr_o), .lu_row_valid_o(lu_row_valid_o),
    .lu_wr_row_i(lu_wr_row_i), .lu_wr_addr_i(lu_wr_addr_i),
    .lu_wr_valid_i(lu_wr_valid_i), .lu_wr_ready_o(lu_wr_ready_o)
  );

  always #5 clk = ~clk;

  // Reference model: the matrix as an array of rows plus which rows were loaded.
  logic [ROW_W-1:0] mem_m [SIZE];
  logic [SIZE-1:0]  loaded = '0;
  logic [ROW_W-1:0] host_q[$];
  logic [ROW_W-1:0] lu_q[$];
  logic [AW-1:0]    lu_addr_q[$];

  int n_checks = 0, n_pass = 0, n_done = 0, k;
  row_t             r;
  logic [ROW_W-1:0] one_row, fill_5a;

  function automatic void chk(string name, logic [ROW_W-1:0] act, logic [ROW_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    chk(name, ROW_W'(act), ROW_W'(exp));
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] v;
    for (int i = 0; i < int'(ROW_W / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    go_i = 1'b0; host_wr_valid_i = 1'b0; host_rd_valid_i = 1'b0;
    lu_rd_addr_valid_i = 1'b0; lu_wr_valid_i = 1'b0;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [ROW_W-1:0] d);
    host_wr_valid_i = 1'b1; host_wr_addr_i = a; host_wr_row_i = d;
    mem_m[a] = d; loaded[a] = 1'b1;
  endtask

  task automatic host_rd(input logic [AW-1:0] a);
    host_rd_valid_i = 1'b1; host_rd_addr_i = a;
    host_q.push_back(mem_m[a]);
  endtask

  task automatic lu_wr(input logic [AW-1:0] a, input logic [ROW_W-1:0] d, input logic taken);
    lu_wr_valid_i = 1'b1; lu_wr_addr_i = a; lu_wr_row_i = d;
    if (taken) mem_m[a] = d;
  endtask

  task automatic lu_rd(input logic [AW-1:0] a, input logic served);
    lu_rd_addr_valid_i = 1'b1; lu_rd_addr_i = a;
    if (served) begin lu_q.push_back(mem_m[a]); lu_addr_q.push_back(a); end
  endtask

  // Monitor: pop the expected response whenever a read result is presented.
  always @(negedge clk) begin
    if (host_rd_row_valid_o) begin
      if (host_q.size() == 0) begin
        n_checks++; $display("FAIL host_rd_unexpected: got valid=1 required valid=0");
      end else chk("host_rd_row", host_rd_row_o, host_q.pop_front());
    end
    if (lu_row_valid_o) begin
      if (lu_q.size() == 0) begin
        n_checks++; $display("FAIL lu_rd_unexpected: got valid=1 required valid=0");
      end else begin
        chk("lu_row", lu_row_o, lu_q.pop_front());
        chk("lu_row_addr", ROW_W'(lu_row_addr_o), ROW_W'(lu_addr_q.pop_front()));
      end
    end
    if (done_o) n_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(); tick();
    chk1("rst_host_wr_ready", host_wr_ready_o, 1'b1);
    chk1("rst_host_rd_ready", host_rd_ready_o, 1'b1);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_lu_start", lu_start_o, 1'b0);
    chk1("rst_lu_wr_ready", lu_wr_ready_o, 1'b0);
    chk1("rst_lu_row_valid", lu_row_valid_o, 1'b0);
    rst_i = 1'b0;

    // Load element(i,j) real = i*4+j, imag = 0, then read row 2
    for (int i = 0; i < int'(SIZE); i++) begin
      r = '0;
      for (int j = 0; j < int'(SIZE); j++) r[j].re = WIDTH'(i * 4 + j);
      host_wr(AW'(i), ROW_W'(r));
      tick();
    end
    host_rd(AW'(2)); tick();
    tick();

    // Random host traffic, including same-cycle write/read of one row
    for (int c = 0; c < 120; c++) begin
      logic [AW-1:0] wa, ra;
      wa = AW'($urandom_range(SIZE - 1));
      ra = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(SIZE - 1));
      if ($urandom_range(1) == 1) host_wr(wa, rand_row());
      if ($urandom_range(1) == 1) host_rd(ra);
      tick();
    end

    // Incomplete load: go rejected
    rst_i = 1'b1; tick(); rst_i = 1'b0; loaded = '0;
    host_wr(AW'(0), rand_row()); tick();
    host_wr(AW'(1), rand_row()); tick();
    host_wr(AW'(3), rand_row()); tick();
    go_i = 1'b1; tick();
    chk1("go_partial_err", err_o, 1'b1);
    chk1("go_partial_busy", busy_o, 1'b0);
    chk1("go_partial_start", lu_start_o, 1'b0);
    // Engine traffic while idle is ignored
    lu_wr(AW'(0), rand_row(), 1'b0); lu_rd(AW'(0), 1'b0); tick();
    chk1("err_one_cycle", err_o, 1'b0);
    chk1("no_start_idle", lu_start_o, 1'b0);
    host_rd(AW'(0)); tick();

    // Full load and a run with directed and random engine traffic
    host_wr(AW'(2), rand_row()); tick();
    go_i = 1'b1; tick();
    chk1("start_pulse", lu_start_o, 1'b1);
    chk1("busy_start", busy_o, 1'b1);
    chk1("host_ready_busy", host_wr_ready_o, 1'b0);
    lu_busy_i = 1'b1; lu_rd(AW'(3), 1'b0); tick();
    chk1("start_single", lu_start_o, 1'b0);
    lu_rd(AW'(1), 1'b1); lu_wr(AW'(0), rand_row(), 1'b0); tick();
    chk1("lu_wr_ready_run", lu_wr_ready_o, 1'b1);
    one_row = ROW_W'(row_fill(cplx_t'{im: '0, re: 64'h3FF0_0000_0000_0000}));
    lu_wr(AW'(1), one_row, 1'b1); tick();
    fill_5a = {(ROW_W / 8){8'h5A}};
    lu_wr(AW'(2), fill_5a, 1'b1); lu_rd(AW'(2), 1'b1); tick();
    for (int c = 0; c < 24; c++) begin
      logic [AW-1:0] wa, ra;
      wa = AW'($urandom_range(SIZE - 1));
      ra = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(SIZE - 1));
      if (c < 20 && wa != AW'(1) && $urandom_range(1) == 1) lu_wr(wa, rand_row(), 1'b1);
      if ($urandom_range(1) == 1) lu_rd(ra, 1'b1);
      go_i = ($urandom_range(7) == 0);
      tick();
    end
    lu_busy_i = 1'b0; tick();
    chk1("done_pulse", done_o, 1'b1);
    chk1("busy_done", busy_o, 1'b1);
    tick();
    chk1("done_single", done_o, 1'b0);
    chk1("busy_idle", busy_o, 1'b0);
    chk1("lu_wr_ready_idle", lu_wr_ready_o, 1'b0);
    loaded = '0;
    chk("row1_is_one", mem_m[1], one_row);
    for (int i = 0; i < int'(SIZE); i++) begin host_rd(AW'(i)); tick(); end
    go_i = 1'b1; tick();
    chk1("go_after_done_err", err_o, ~&loaded);

    // Start timeout: engine never raises busy
    for (int i = 0; i < int'(SIZE); i++) begin host_wr(AW'(i), rand_row()); tick(); end
    go_i = 1'b1; tick();
    chk1("to_start_pulse", lu_start_o, 1'b1);
    k = 0;
    for (int c = 1; c <= int'(START_TO) + 4; c++) begin
      tick();
      if (err_o) begin k = c; break; end
    end
    chk("timeout_latency", ROW_W'(k), ROW_W'(START_TO + 1));
    chk1("timeout_busy", busy_o, 1'b0);
    chk1("timeout_host_ready", host_wr_ready_o, 1'b1);
    tick();
    go_i = 1'b1; tick();
    chk1("mask_kept_start", lu_start_o, 1'b1);

    // Reset during RUN aborts and clears the load mask
    lu_busy_i = 1'b1; tick(); tick();
    chk1("run_before_rst", lu_wr_ready_o, 1'b1);
    rst_i = 1'b1; tick(); rst_i = 1'b0; lu_busy_i = 1'b0; loaded = '0;
    chk1("rst_run_busy", busy_o, 1'b0);
    chk1("rst_run_host_ready", host_wr_ready_o, 1'b1);
    chk1("rst_run_lu_wr_ready", lu_wr_ready_o, 1'b0);
    go_i = 1'b1; tick();
    chk1("rst_run_go_err", err_o, ~&loaded);
    chk1("rst_run_no_start", lu_start_o, 1'b0);
    host_rd(AW'(3)); tick();

    tick(); tick(); tick();
    chk("host_q_drained", ROW_W'(host_q.size()), '0);
    chk("lu_q_drained", ROW_W'(lu_q.size()), '0);
    chk("done_count", ROW_W'(n_done), ROW_W'(1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
